// File: rtl/tx_frame_queue.sv
// Store-and-forward transmit frame buffer: byte RAM plus length-descriptor FIFO.
// Bad frames are discarded by rewinding the write pointer to the last commit point.
module tx_frame_queue #(
   parameter int DELAY   = 2,
   parameter int AW      = 12,
   parameter int PW      = 5,
   parameter int MAX_LEN = 1514
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic        in_eof,
   input  logic [7:0]  in_data,
   output logic        in_bp,
   input  logic        data_fifo_rd,
   output logic [7:0]  data_fifo_din,
   input  logic        ptr_fifo_rd,
   output logic [15:0] ptr_fifo_din,
   output logic        ptr_fifo_empty,
   output logic [15:0] drop_cnt
);
   localparam int LW         = 11;
   localparam int RAM_DEPTH  = 1 << AW;
   localparam int DESC_DEPTH = 1 << PW;

   localparam logic [AW:0]     PTR_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0]     PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]     RAM_FULL  = {1'b1, {AW{1'b0}}};
   localparam logic [PW:0]     DP_ZERO   = {(PW+1){1'b0}};
   localparam logic [PW:0]     DESC_FULL = {1'b1, {PW{1'b0}}};
   localparam logic [PW:0]     DESC_HIGH = {1'b0, {PW{1'b1}}};
   localparam logic [LW-1:0]   LEN_ZERO  = {LW{1'b0}};
   localparam logic [LW-1:0]   LEN_ONE   = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0]   LEN_MAX   = LW'(MAX_LEN);
   localparam logic [AW+1:0]   BP_LEVEL  = (AW+2)'(MAX_LEN);

   // Registers update without delay; DELAY only exists so legacy instantiations still elaborate.
   if (DELAY < 0) begin : g_delay_unsupported
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECV    = 2'd1,
      ST_DISCARD = 2'd2
   } wr_state_t;

   wr_state_t       state_r, state_nxt_s;
   logic [AW:0]     wr_ptr_r, wr_ptr_nxt_s;
   logic [AW:0]     commit_ptr_r, commit_ptr_nxt_s;
   logic [AW:0]     rd_ptr_r, base_ptr_s;
   logic [LW-1:0]   len_r, len_nxt_s, new_len_s;
   logic [PW:0]     dwr_ptr_r, drd_ptr_r, desc_cnt_s, desc_cnt_nxt_s;
   logic [AW+1:0]   free_s;
   logic            restart_s, full_s, oversize_s, accept_s;
   logic            ram_we_s, push_s, pop_s, drop_s, push_room_s, data_rd_s;
   logic [7:0]      data_fifo_din_r;
   logic [15:0]     ptr_fifo_din_r, drop_cnt_r;
   logic            empty_r, in_bp_r;

   logic [7:0]      ram_r      [RAM_DEPTH];
   logic [LW-1:0]   desc_mem_r [DESC_DEPTH];

   assign desc_cnt_s     = dwr_ptr_r - drd_ptr_r;
   assign pop_s          = ptr_fifo_rd & (desc_cnt_s != DP_ZERO);
   // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
   assign push_room_s    = (desc_cnt_s != DESC_FULL) | pop_s;
   assign desc_cnt_nxt_s = (dwr_ptr_r + {{PW{1'b0}}, push_s}) - (drd_ptr_r + {{PW{1'b0}}, pop_s});
   assign data_rd_s      = data_fifo_rd & (rd_ptr_r != commit_ptr_r);
   assign restart_s      = (state_r == ST_RECV) & in_sof;
   assign base_ptr_s     = restart_s ? commit_ptr_r : wr_ptr_r;
   assign new_len_s      = (in_sof ? LEN_ZERO : len_r) + LEN_ONE;
   assign full_s         = (base_ptr_s - rd_ptr_r) == RAM_FULL;
   assign oversize_s     = new_len_s > LEN_MAX;
   assign accept_s       = in_valid & (in_sof | (state_r == ST_RECV));
   assign free_s         = {1'b0, RAM_FULL} - {1'b0, (wr_ptr_r - rd_ptr_r)};

   // Write-side frame FSM: decide whether the current byte is stored, committed or dropped
   always_comb begin
      state_nxt_s      = state_r;
      wr_ptr_nxt_s     = wr_ptr_r;
      commit_ptr_nxt_s = commit_ptr_r;
      len_nxt_s        = len_r;
      ram_we_s         = 1'b0;
      push_s           = 1'b0;
      drop_s           = 1'b0;
      case (state_r)
         ST_IDLE, ST_RECV: begin
            if (accept_s) begin
               if (full_s || oversize_s) begin
                  drop_s       = 1'b1;
                  wr_ptr_nxt_s = commit_ptr_r;
                  state_nxt_s  = in_eof ? ST_IDLE : ST_DISCARD;
               end else begin
                  ram_we_s     = 1'b1;
                  drop_s       = restart_s;
                  wr_ptr_nxt_s = base_ptr_s + PTR_ONE;
                  len_nxt_s    = new_len_s;
                  if (!in_eof) begin
                     state_nxt_s = ST_RECV;
                  end else if (push_room_s) begin
                     state_nxt_s      = ST_IDLE;
                     push_s           = 1'b1;
                     commit_ptr_nxt_s = base_ptr_s + PTR_ONE;
                  end else begin
                     state_nxt_s  = ST_IDLE;
                     drop_s       = 1'b1;
                     wr_ptr_nxt_s = commit_ptr_r;
                  end
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_DISCARD: begin
            if (in_valid && in_eof) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DISCARD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Write-side state, pointers and frame length
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         wr_ptr_r     <= PTR_ZERO;
         commit_ptr_r <= PTR_ZERO;
         len_r        <= LEN_ZERO;
         dwr_ptr_r    <= DP_ZERO;
      end else begin
         state_r      <= state_nxt_s;
         wr_ptr_r     <= wr_ptr_nxt_s;
         commit_ptr_r <= commit_ptr_nxt_s;
         len_r        <= len_nxt_s;
         dwr_ptr_r    <= dwr_ptr_r + {{PW{1'b0}}, push_s};
      end
   end

   // Data RAM and descriptor storage writes
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_r[base_ptr_s[AW-1:0]] <= in_data;
      end
      if (push_s) begin
         desc_mem_r[dwr_ptr_r[PW-1:0]] <= new_len_s;
      end
   end

   // Read side, status flags and drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r        <= PTR_ZERO;
         drd_ptr_r       <= DP_ZERO;
         data_fifo_din_r <= 8'h00;
         ptr_fifo_din_r  <= 16'h0000;
         empty_r         <= 1'b1;
         in_bp_r         <= 1'b0;
         drop_cnt_r      <= 16'h0000;
      end else begin
         if (data_rd_s) begin
            data_fifo_din_r <= ram_r[rd_ptr_r[AW-1:0]];
            rd_ptr_r        <= rd_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            ptr_fifo_din_r <= {{(16-LW){1'b0}}, desc_mem_r[drd_ptr_r[PW-1:0]]};
            drd_ptr_r      <= drd_ptr_r + {{PW{1'b0}}, 1'b1};
         end
         empty_r <= (desc_cnt_nxt_s == DP_ZERO);
         in_bp_r <= (free_s < BP_LEVEL) | (desc_cnt_s >= DESC_HIGH);
         if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
         end
      end
   end

   assign in_bp          = in_bp_r;
   assign data_fifo_din  = data_fifo_din_r;
   assign ptr_fifo_din   = ptr_fifo_din_r;
   assign ptr_fifo_empty = empty_r;
   assign drop_cnt       = drop_cnt_r;

endmodule

// File: tb/tb_tx_frame_queue.sv
// Self-checking bench for tx_frame_queue: queue-based frame model, per-cycle compare,
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_tx_frame_queue;
   localparam int MAX_LEN   = 1514;
   localparam int RAM_BYTES = 4096;
   localparam int DESC_MAX  = 32;

   logic        clk, rst;
   logic        in_valid, in_sof, in_eof;
   logic [7:0]  in_data;
   logic        in_bp;
   logic        data_fifo_rd;
   logic [7:0]  data_fifo_din;
   logic        ptr_fifo_rd;
   logic [15:0] ptr_fifo_din;
   logic        ptr_fifo_empty;
   logic [15:0] drop_cnt;

   tx_frame_queue dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data),
      .in_bp(in_bp),
      .data_fifo_rd(data_fifo_rd), .data_fifo_din(data_fifo_din),
      .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_din(ptr_fifo_din),
      .ptr_fifo_empty(ptr_fifo_empty), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Reference model: committed bytes, committed lengths, bytes of the frame in progress
   byte unsigned data_q[$];
   int           desc_q[$];
   byte unsigned cur_q[$];
   int           m_state;   // 0 idle, 1 receiving, 2 discarding
   int           m_drop;
   logic [7:0]   exp_dout;
   logic [15:0]  exp_pdin;
   logic         exp_bp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      data_q.delete(); desc_q.delete(); cur_q.delete();
      m_state = 0; m_drop = 0;
      exp_dout = 8'h00; exp_pdin = 16'h0000; exp_bp = 1'b0;
   endtask

   // Applies one clock edge worth of inputs to the model, using pre-edge occupancy
   task automatic model_edge();
      int pre_data = data_q.size();
      int pre_desc = desc_q.size();
      bit popped   = 1'b0;
      bit dropped  = 1'b0;
      bit bp_n;
      bp_n = ((RAM_BYTES - (pre_data + cur_q.size())) < MAX_LEN) || (pre_desc >= DESC_MAX - 1);
      if (data_fifo_rd && pre_data > 0) exp_dout = data_q.pop_front();
      if (ptr_fifo_rd && pre_desc > 0) begin
         exp_pdin = 16'(desc_q.pop_front());
         popped = 1'b1;
      end
      if (in_valid) begin
         if (m_state == 2) begin
            if (in_eof) m_state = 0;
         end else if (in_sof || m_state == 1) begin
            if (in_sof) begin
               if (m_state == 1) dropped = 1'b1;
               cur_q.delete();
            end
            if ((pre_data + cur_q.size() == RAM_BYTES) || (cur_q.size() + 1 > MAX_LEN)) begin
               dropped = 1'b1;
               cur_q.delete();
               m_state = in_eof ? 0 : 2;
            end else begin
               cur_q.push_back(in_data);
               if (in_eof) begin
                  if (pre_desc < DESC_MAX || popped) begin
                     desc_q.push_back(cur_q.size());
                     foreach (cur_q[i]) data_q.push_back(cur_q[i]);
                  end else begin
                     dropped = 1'b1;
                  end
                  cur_q.delete();
                  m_state = 0;
               end else begin
                  m_state = 1;
               end
            end
         end
      end
      if (dropped && m_drop < 65535) m_drop++;
      exp_bp = bp_n;
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("data_fifo_din", 32'(data_fifo_din), 32'(exp_dout));
         chk("ptr_fifo_din", 32'(ptr_fifo_din), 32'(exp_pdin));
         chk("ptr_fifo_empty", 32'(ptr_fifo_empty), 32'(desc_q.size() == 0));
         chk("in_bp", 32'(in_bp), 32'(exp_bp));
         chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      end
   end

   task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d,
                       input logic drd, input logic prd);
      in_valid = v; in_sof = s; in_eof = e; in_data = d;
      data_fifo_rd = drd; ptr_fifo_rd = prd;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++)
         step(1'b1, i == 0, i == n - 1, 8'(base + 8'(i)), 1'b0, 1'b0);
   endtask

   task automatic drain_all();
      int guard = 0;
      while (desc_q.size() > 0 && guard < 100) begin
         int n = desc_q[0];
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
         for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         guard++;
      end
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
      data_fifo_rd = 1'b0; ptr_fifo_rd = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      do_reset();
      chk("reset_empty", 32'(ptr_fifo_empty), 32'd1);
      chk("reset_bp", 32'(in_bp), 32'd0);
      chk("reset_drop", 32'(drop_cnt), 32'd0);

      // 64-byte frame 0x00..0x3F
      send_frame(64, 8'h00);
      chk("empty_after_commit", 32'(ptr_fifo_empty), 32'd0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("desc_64", 32'(ptr_fifo_din), 32'h0040);
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("byte_64", 32'(data_fifo_din), 32'(i));
      end

      // 1-byte frame with sof and eof together
      send_frame(1, 8'hA5);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("desc_1", 32'(ptr_fifo_din), 32'h0001);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("byte_1", 32'(data_fifo_din), 32'hA5);

      // Oversize frame, then a normal frame from address 0
      do_reset();
      send_frame(1515, 8'h00);
      idle(1);
      chk("oversize_drop", 32'(drop_cnt), 32'd1);
      chk("oversize_empty", 32'(ptr_fifo_empty), 32'd1);
      send_frame(60, 8'h10);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("desc_60", 32'(ptr_fifo_din), 32'h003C);
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("byte_60", 32'(data_fifo_din), 32'(8'h10 + i));
      end

      // sof arriving mid-frame restarts at the commit point
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      send_frame(20, 8'h80);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("desc_20", 32'(ptr_fifo_din), 32'h0014);
      chk("restart_drop", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("byte_20", 32'(data_fifo_din), 32'(8'h80 + i));
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("empty_pop_hold", 32'(ptr_fifo_din), 32'h0014);

      // Fill the RAM with maximum-size frames, drain, and wrap the pointers
      do_reset();
      send_frame(1514, 8'h01);
      send_frame(1514, 8'h02);
      idle(1);
      chk("fill_bp", 32'(in_bp), 32'd1);
      send_frame(1514, 8'h03);
      idle(1);
      chk("full_drop", 32'(drop_cnt), 32'd1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("fill_desc", 32'(ptr_fifo_din), 32'd1514);
      for (int i = 0; i < 1514; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
      chk("drain_bp", 32'(in_bp), 32'd0);
      send_frame(1000, 8'h04);
      send_frame(1200, 8'h05);
      drain_all();

      // Descriptor FIFO full, then push and pop in the same cycle
      do_reset();
      for (int f = 0; f < 34; f++) send_frame(1, 8'(f));
      chk("desc_full_drop", 32'(drop_cnt), 32'd2);
      step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("push_pop_full", 32'(drop_cnt), 32'd2);
      chk("push_pop_desc", 32'(ptr_fifo_din), 32'h0001);
      drain_all();

      // Randomized traffic
      do_reset();
      begin
         int rem = 0;
         bit first = 1'b0;
         logic v, s, e;
         for (int c = 0; c < 5000; c++) begin
            v = 1'b0; s = 1'b0; e = 1'b0;
            if (rem == 0 && !in_bp && $urandom_range(0, 3) == 0) begin
               rem = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1400, 1520))
                                                  : int'($urandom_range(1, 80));
               first = 1'b1;
            end
            if (rem > 0 && $urandom_range(0, 4) != 0) begin
               v = 1'b1;
               if (!first && $urandom_range(0, 99) == 0) begin
                  rem = int'($urandom_range(1, 40));
                  first = 1'b1;
               end
               s = first;
               e = (rem == 1);
               first = 1'b0;
               rem--;
            end else if (rem == 0 && $urandom_range(0, 30) == 0) begin
               v = 1'b1;
               e = 1'($urandom_range(0, 1));
            end
            step(v, s, e, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
         end
      end
      idle(2);
      drain_all();

      // Asynchronous reset with frames queued and one in progress
      do_reset();
      send_frame(5, 8'h20);
      send_frame(6, 8'h30);
      send_frame(7, 8'h40);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b0, 8'h50, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b0, 8'h60, 1'b0, 1'b0);
      chk("pre_reset_drop", 32'(drop_cnt), 32'd1);
      chk("pre_reset_desc", 32'(ptr_fifo_din), 32'h0005);
      chk_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_reset_empty", 32'(ptr_fifo_empty), 32'd1);
      chk("mid_reset_desc", 32'(ptr_fifo_din), 32'd0);
      chk("mid_reset_drop", 32'(drop_cnt), 32'd0);
      do_reset();
      send_frame(3, 8'h70);
      drain_all();
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
